// File: rtl/exibe_sequencia.sv
// Plays a stored sequence of LED patterns: each item is fetched from an external
// synchronous ROM, lit for TEMPO_ON cycles, then blanked for TEMPO_OFF cycles.
module exibe_sequencia #(
    parameter int TEMPO_ON  = 500,
    parameter int TEMPO_OFF = 250
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] dado,
    output logic [3:0] endereco,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] db_estado
);

    localparam int TEMPO_MAX = (TEMPO_ON > TEMPO_OFF) ? TEMPO_ON : TEMPO_OFF;
    localparam int CW        = $clog2(TEMPO_MAX + 1);

    localparam logic [CW-1:0] ULTIMO_CARREGA = CW'(1);
    localparam logic [CW-1:0] ULTIMO_ON      = CW'(TEMPO_ON - 1);
    localparam logic [CW-1:0] ULTIMO_OFF     = CW'(TEMPO_OFF - 1);

    typedef enum logic [3:0] {
        OCIOSO  = 4'd0,
        CARREGA = 4'd1,
        ACENDE  = 4'd2,
        APAGA   = 4'd3,
        FIM     = 4'd4
    } estado_t;

    estado_t       estado;
    logic [3:0]    reg_limite;
    logic [3:0]    reg_leds;
    logic [CW-1:0] contador;

    // NOTE: all sequential state is updated with non-blocking assignments so every
    // branch below sees the pre-edge values, regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= OCIOSO;
            endereco   <= 4'd0;
            reg_limite <= 4'd0;
            reg_leds   <= 4'd0;
            contador   <= '0;
            ocupado    <= 1'b0;
            pronto     <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    contador <= '0;
                    pronto   <= 1'b0;
                    ocupado  <= 1'b0;
                    if (iniciar) begin
                        reg_limite <= limite;
                        endereco   <= 4'd0;
                        ocupado    <= 1'b1;
                        estado     <= CARREGA;
                    end
                end

                // Two cycles here cover the ROM's one-cycle read latency.
                CARREGA: begin
                    if (contador == ULTIMO_CARREGA) begin
                        reg_leds <= dado;
                        contador <= '0;
                        estado   <= ACENDE;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end

                ACENDE: begin
                    if (contador == ULTIMO_ON) begin
                        contador <= '0;
                        estado   <= APAGA;
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end

                APAGA: begin
                    if (contador == ULTIMO_OFF) begin
                        contador <= '0;
                        if (endereco == reg_limite) begin
                            ocupado <= 1'b0;
                            pronto  <= 1'b1;
                            estado  <= FIM;
                        end else begin
                            endereco <= endereco + 4'd1;
                            estado   <= CARREGA;
                        end
                    end else begin
                        contador <= contador + 1'b1;
                    end
                end

                FIM: begin
                    pronto   <= 1'b0;
                    contador <= '0;
                    estado   <= OCIOSO;
                end

                default: begin
                    contador <= '0;
                    ocupado  <= 1'b0;
                    pronto   <= 1'b0;
                    estado   <= OCIOSO;
                end
            endcase
        end
    end

    // LEDs are dark everywhere except while the fetched item is being shown.
    assign leds      = (estado == ACENDE) ? reg_leds : 4'd0;
    assign db_estado = estado;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Self-checking bench for exibe_sequencia with TEMPO_ON=4, TEMPO_OFF=2 and a
// behavioural sync ROM holding 1,2,4,8 repeating.
module tb_exibe_sequencia;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int ITEM = 2 + ON + OFF;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic [3:0] limite;
    logic [3:0] dado;
    logic [3:0] endereco;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] db_estado;

    int checks   = 0;
    int failures = 0;

    exibe_sequencia #(.TEMPO_ON(ON), .TEMPO_OFF(OFF)) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .limite    (limite),
        .dado      (dado),
        .endereco  (endereco),
        .leds      (leds),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .db_estado (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // External sync_rom_16x4 model: one-cycle registered read.
    always @(posedge clock) dado <= 4'(1 << (endereco % 4));

    typedef struct {
        logic       iniciar;
        logic [3:0] limite;
        logic [3:0] db_estado;
        logic [3:0] endereco;
        logic [3:0] leds;
        logic       ocupado;
        logic       pronto;
    } vec_t;

    vec_t tbl[11];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_st, input logic [3:0] e_end,
                             input logic [3:0] e_leds, input logic e_oc, input logic e_pr);
        check({tag, " db_estado"}, 32'(db_estado), 32'(e_st));
        check({tag, " endereco"},  32'(endereco),  32'(e_end));
        check({tag, " leds"},      32'(leds),      32'(e_leds));
        check({tag, " ocupado"},   32'(ocupado),   32'(e_oc));
        check({tag, " pronto"},    32'(pronto),    32'(e_pr));
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        iniciar = 1'b0;
        step();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Starts a sequence and checks every cycle up to FIM and the return to OCIOSO.
    // With hold set, iniciar stays high (with one drop/rise inside ACENDE of each item)
    // and a fresh start is expected right after the return to OCIOSO.
    task automatic run_sequence(input string tag, input logic [3:0] lim, input logic [3:0] lim_after,
                                input bit hold, input int n_items);
        int total;
        int n_pronto;
        int i;
        int c;
        logic [3:0] e_st;
        logic [3:0] e_leds;
        total = ITEM * n_items;
        n_pronto = 0;
        @(negedge clock);
        iniciar = 1'b1;
        limite  = lim;
        step();
        for (int t = 0; t <= total; t++) begin
            if (pronto) n_pronto++;
            if (t < total) begin
                i = t / ITEM;
                c = t % ITEM;
                e_st   = (c < 2) ? 4'd1 : (c < 2 + ON) ? 4'd2 : 4'd3;
                e_leds = (e_st == 4'd2) ? 4'(1 << (i % 4)) : 4'd0;
                check_all($sformatf("%s t=%0d", tag, t), e_st, 4'(i), e_leds, 1'b1, 1'b0);
            end else begin
                check_all($sformatf("%s fim", tag), 4'd4, 4'(n_items - 1), 4'd0, 1'b0, 1'b1);
            end
            @(negedge clock);
            iniciar = hold && ((t % ITEM) != 2);
            limite  = lim_after;
            step();
        end
        check({tag, " pronto count"}, 32'(n_pronto), 32'd1);
        check_all({tag, " ocioso"}, 4'd0, 4'(n_items - 1), 4'd0, 1'b0, 1'b0);
        if (hold) begin
            step();
            check_all({tag, " restart"}, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0);
            do_reset();
        end
    endtask

    initial begin
        reset   = 1'b1;
        iniciar = 1'b1;
        limite  = 4'd3;
        step();
        step();
        check_all("reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset   = 1'b0;
        iniciar = 1'b0;
        step();
        check_all("idle", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        // Single item (limite=0); limite moves to 7 after the start and must be ignored.
        tbl[0]  = '{1'b1, 4'd0, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 4'd7, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'd7, 4'd2, 4'd0, 4'd1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'd7, 4'd2, 4'd0, 4'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'd7, 4'd2, 4'd0, 4'd1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'd7, 4'd2, 4'd0, 4'd1, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 4'd7, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 4'd7, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'd7, 4'd4, 4'd0, 4'd0, 1'b0, 1'b1};
        tbl[9]  = '{1'b0, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 4'd5, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0};
        for (int k = 0; k < 11; k++) begin
            @(negedge clock);
            iniciar = tbl[k].iniciar;
            limite  = tbl[k].limite;
            step();
            check_all($sformatf("vec%0d", k), tbl[k].db_estado, tbl[k].endereco,
                      tbl[k].leds, tbl[k].ocupado, tbl[k].pronto);
        end

        run_sequence("four", 4'd3, 4'd3, 1'b0, 4);
        run_sequence("busy", 4'd1, 4'd1, 1'b1, 2);
        run_sequence("limchg", 4'd3, 4'd0, 1'b0, 4);

        // Reset mid-ACENDE of item 2, with iniciar high on the same edge.
        @(negedge clock);
        iniciar = 1'b1;
        limite  = 4'd3;
        step();
        @(negedge clock);
        iniciar = 1'b0;
        for (int k = 0; k < 2 * ITEM + 3; k++) step();
        check_all("pre-reset", 4'd2, 4'd2, 4'd4, 1'b1, 1'b0);
        @(negedge clock);
        reset   = 1'b1;
        iniciar = 1'b1;
        step();
        check_all("mid reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        @(negedge clock);
        reset   = 1'b0;
        iniciar = 1'b0;
        step();
        check_all("post reset", 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);

        run_sequence("full", 4'd15, 4'd15, 1'b0, 16);
        step();
        check("full hold endereco", 32'(endereco), 32'd15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
